// File: rtl/systolic_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_feed_ctrl
// Brief    : Operand buffer and skewed edge sequencer for an N x N
//            output-stationary mac_cell systolic array. Clears the cell
//            accumulators, streams skewed A rows / B columns, waits for the
//            pipeline to drain, then pulses done.
// Revision : 1.0  initial release
// ============================================================================
module systolic_feed_ctrl #(
    parameter int N       = 4,
    parameter int DW      = 8,
    parameter int MAC_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  wr_mat,
    input  logic [$clog2(N)-1:0]  wr_row,
    input  logic [$clog2(N)-1:0]  wr_col,
    input  logic [DW-1:0]         wr_data,
    output logic                  wr_rej,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  acc_clr,
    output logic [N*DW-1:0]       a_edge,
    output logic [N*DW-1:0]       b_edge
);

    // Counter covers both the FEED step index and the DRAIN wait.
    localparam int            TW       = $clog2(3*N + MAC_LAT);
    localparam logic [TW-1:0] C_T_LAST = TW'(3*N - 3);
    localparam logic [TW-1:0] C_D_LAST = TW'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_t;
    logic [DW-1:0]   r_a [N][N];
    logic [DW-1:0]   r_b [N][N];

    logic [TW-1:0]   w_t_nxt;
    logic [N*DW-1:0] w_a_skew;
    logic [N*DW-1:0] w_b_skew;

    // Skewed edge values for the FEED step that the next edge will enter.
    // Row i carries A[i][k] when t = i+k; column j carries B[k][j] when t = j+k.
    always_comb begin
        w_t_nxt  = (r_state == S_FEED) ? (r_t + TW'(1)) : '0;
        w_a_skew = '0;
        w_b_skew = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (int'(w_t_nxt) == i + k) begin
                    w_a_skew[i*DW +: DW] = r_a[i][k];
                    w_b_skew[i*DW +: DW] = r_b[k][i];
                end
            end
        end
    end

    // Sequencer FSM, operand buffers and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_t     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            acc_clr <= 1'b0;
            wr_rej  <= 1'b0;
            a_edge  <= '0;
            b_edge  <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_a[i][j] <= '0;
                    r_b[i][j] <= '0;
                end
            end
        end else begin
            done    <= 1'b0;
            acc_clr <= 1'b0;
            wr_rej  <= 1'b0;

            // Host writes land only while the array is not being fed.
            if (wr_en) begin
                if (r_state == S_IDLE || r_state == S_DONE) begin
                    if (wr_mat) r_b[wr_row][wr_col] <= wr_data;
                    else        r_a[wr_row][wr_col] <= wr_data;
                end else begin
                    wr_rej <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_CLEAR;
                        busy    <= 1'b1;
                        acc_clr <= 1'b1;
                        a_edge  <= '0;
                        b_edge  <= '0;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_FEED;
                    r_t     <= '0;
                    a_edge  <= w_a_skew;
                    b_edge  <= w_b_skew;
                end
                S_FEED: begin
                    if (r_t == C_T_LAST) begin
                        r_state <= S_DRAIN;
                        r_t     <= '0;
                        a_edge  <= '0;
                        b_edge  <= '0;
                    end else begin
                        r_t     <= w_t_nxt;
                        a_edge  <= w_a_skew;
                        b_edge  <= w_b_skew;
                    end
                end
                S_DRAIN: begin
                    if (r_t == C_D_LAST) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_t     <= r_t + TW'(1);
                    end
                end
                S_DONE: begin
                    // A start seen here is dropped; the host must re-issue it.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_feed_ctrl
// Brief    : Self-checking bench for systolic_feed_ctrl. A behavioural mac_cell
//            array is driven from the edge outputs; expected C matrices and
//            done cycles are queued at start and compared when done pulses.
// Revision : 1.0  initial release
// ============================================================================
module tb_systolic_feed_ctrl;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = N*N*DW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic            wr_mat = 1'b0;
    logic [1:0]      wr_row = '0;
    logic [1:0]      wr_col = '0;
    logic [DW-1:0]   wr_data = '0;
    logic            wr_rej;
    logic            start = 1'b0;
    logic            busy;
    logic            done;
    logic            acc_clr;
    logic [N*DW-1:0] a_edge;
    logic [N*DW-1:0] b_edge;

    systolic_feed_ctrl #(.N(N), .DW(DW), .MAC_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_mat(wr_mat),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_rej(wr_rej),
        .start(start), .busy(busy), .done(done), .acc_clr(acc_clr),
        .a_edge(a_edge), .b_edge(b_edge)
    );

    always #5 clk = ~clk;

    int ec = 0;
    always @(posedge clk) ec++;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    typedef struct {
        logic [CW-1:0] c;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ec);
        end
    endtask

    // Behavioural output-stationary mac_cell array fed from the DUT edges.
    logic [DW-1:0] pa [N][N];
    logic [DW-1:0] pb [N][N];
    logic [DW-1:0] cc [N][N];
    logic [DW-1:0] ain, bin;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pa[i][j] <= '0; pb[i][j] <= '0; cc[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    if (j == 0) ain = a_edge[i*DW +: DW];
                    else        ain = pa[i][j-1];
                    if (i == 0) bin = b_edge[j*DW +: DW];
                    else        bin = pb[i-1][j];
                    pa[i][j] <= ain;
                    pb[i][j] <= bin;
                    cc[i][j] <= acc_clr ? '0 : DW'(cc[i][j] + ain * bin);
                end
        end
    end

    function automatic logic [CW-1:0] model_c();
        logic [CW-1:0] r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                r[(i*N+j)*DW +: DW] = cc[i][j];
        return r;
    endfunction

    function automatic logic [CW-1:0] mat_c();
        logic [CW-1:0] r = '0;
        logic [DW-1:0] s;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++) s = DW'(s + ma[i][k] * mb[k][j]);
                r[(i*N+j)*DW +: DW] = s;
            end
        return r;
    endfunction

    function automatic logic [N*DW-1:0] exp_a(input int t);
        logic [N*DW-1:0] r = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) r[i*DW +: DW] = ma[i][t-i];
        return r;
    endfunction

    function automatic logic [N*DW-1:0] exp_b(input int t);
        logic [N*DW-1:0] r = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) r[j*DW +: DW] = mb[t-j][j];
        return r;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest queued run.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("c_result", model_c(), e.c);
                check("done_cycle", ec, e.cyc);
            end
        end
    end

    task automatic wr_one(input logic m, input int r, input int c, input logic [DW-1:0] d);
        wr_mat  = m;
        wr_row  = 2'(r);
        wr_col  = 2'(c);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        check("wr_rej_idle", wr_rej, 0);
    endtask

    task automatic load_all();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                wr_one(1'b0, r, c, ma[r][c]);
                wr_one(1'b1, r, c, mb[r][c]);
            end
    endtask

    // mode 0: A=I, B=4r+c+1; mode 1: A=B=4r+c+1; mode 2: irregular values.
    task automatic set_mats(input int mode);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                case (mode)
                    0:       begin ma[r][c] = (r == c) ? 8'd1 : 8'd0; mb[r][c] = 8'(4*r+c+1); end
                    1:       begin ma[r][c] = 8'(4*r+c+1);           mb[r][c] = 8'(4*r+c+1); end
                    default: begin ma[r][c] = 8'(37*r+11*c+200);      mb[r][c] = 8'(23*c+9*r+130); end
                endcase
            end
    endtask

    // Pulse start for one cycle and queue the expected outcome; returns at k=1.
    task automatic go();
        start = 1'b1;
        sb.push_back('{c: mat_c(), cyc: ec + 13});
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int d0;
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_acc_clr", acc_clr, 0);
        check("rst_wr_rej", wr_rej, 0);
        check("rst_a_edge", a_edge, 0);
        check("rst_b_edge", b_edge, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: identity A, busy window and acc_clr timing
        set_mats(0);
        load_all();
        go();
        for (int k = 1; k <= 14; k++) begin
            check("t1_busy", busy, (k >= 1 && k <= 12) ? 1 : 0);
            if (k == 1) check("t1_acc_clr", acc_clr, 1);
            if (k == 2) check("t1_acc_clr_off", acc_clr, 0);
            if (k < 14) @(negedge clk);
        end

        // 2: skewed edge pattern through FEED
        set_mats(1);
        load_all();
        go();
        for (int k = 1; k <= 14; k++) begin
            if (k >= 2 && k <= 11) begin
                check("t2_a_edge", a_edge, exp_a(k - 2));
                check("t2_b_edge", b_edge, exp_b(k - 2));
            end
            if (k == 2) check("t2_t0_a", a_edge, 32'h0000_0001);
            if (k == 5) check("t2_t3_a", a_edge, 32'h0D0A_0704);
            if (k == 8) check("t2_t6_a", a_edge, 32'h1000_0000);
            if (k == 12) check("t2_drain_a", a_edge, 0);
            if (k < 14) @(negedge clk);
        end

        // 3: start pulses during FEED and DRAIN are ignored
        set_mats(2);
        load_all();
        d0 = n_done;
        go();
        for (int k = 1; k <= 22; k++) begin
            start = (k == 5 || k == 12) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("t3_done_count", n_done, d0 + 1);
        check("t3_idle", busy, 0);

        // 4: write during FEED is rejected and leaves the buffers intact
        go();
        for (int k = 1; k <= 14; k++) begin
            if (k == 4) begin
                wr_mat = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'hFF; wr_en = 1'b1;
            end else begin
                wr_en = 1'b0;
            end
            if (k == 5) check("t4_wr_rej", wr_rej, 1);
            if (k == 6) check("t4_wr_rej_off", wr_rej, 0);
            @(negedge clk);
        end
        wr_en = 1'b0;
        go();
        repeat (14) @(negedge clk);

        // 5: asynchronous reset mid-FEED aborts and clears buffers
        go();
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_busy_abort", busy, 0);
        check("t5_a_abort", a_edge, 0);
        check("t5_b_abort", b_edge, 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_idle", busy, 0);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin ma[r][c] = '0; mb[r][c] = '0; end
        go();
        repeat (14) @(negedge clk);
        set_mats(2);
        load_all();
        go();
        repeat (14) @(negedge clk);

        // 6: write with start, then start held for back-to-back runs
        set_mats(1);
        ma[3][3] = 8'd0;
        load_all();
        ma[3][3] = 8'd7;
        wr_mat = 1'b0; wr_row = 2'd3; wr_col = 2'd3; wr_data = 8'd7; wr_en = 1'b1;
        start = 1'b1;
        sb.push_back('{c: mat_c(), cyc: ec + 13});
        sb.push_back('{c: mat_c(), cyc: ec + 27});
        @(negedge clk);
        wr_en = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 14) begin
                check("t6_gap_busy", busy, 0);
                check("t6_gap_acc_clr", acc_clr, 0);
            end
            if (k == 15) begin
                check("t6_acc_clr2", acc_clr, 1);
                start = 1'b0;
            end
            @(negedge clk);
        end

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
